// File: rtl/arb_mux.sv
// Round-robin N:1 arbiter feeding a single registered output slot with ready/valid handshake.
// Optional select-driven mux mode is added by defining ARB_MUX_FORCE_EN (adds force_en/force_sel ports).
module arb_mux #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 2,
    parameter int CW       = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] in_valid,
    input  logic [WIDTH-1:0]    in_data [CHANNELS-1:0],
    output logic [CHANNELS-1:0] in_ready,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    output logic [CW-1:0]       out_chan,
`ifdef ARB_MUX_FORCE_EN
    input  logic                force_en,
    input  logic [CW-1:0]       force_sel,
`endif
    input  logic                out_ready
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    chan_q, chan_d;

    logic             can_load;
    logic             grant_vld;
    logic [CW-1:0]    grant_idx;
    logic [CW-1:0]    cand;
    logic             take;
    logic             freeze_ptr;

    assign can_load = (state_q == ST_EMPTY) || out_ready;

`ifdef ARB_MUX_FORCE_EN
    assign freeze_ptr = force_en;
`else
    assign freeze_ptr = 1'b0;
`endif

    // Search starts at ptr and wraps; ptr is always kept below CHANNELS so one subtraction suffices.
    always_comb begin
        int unsigned idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        idx       = 0;
`ifdef ARB_MUX_FORCE_EN
        if (force_en) begin
            if ((32'(force_sel) < CHANNELS) && in_valid[force_sel]) begin
                grant_vld = 1'b1;
                grant_idx = force_sel;
            end
        end else
`endif
        begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                idx = 32'(ptr_q) + k;
                if (idx >= CHANNELS) begin
                    idx = idx - CHANNELS;
                end
                cand = CW'(idx);
                if (!grant_vld && in_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign take = grant_vld && can_load;

    always_comb begin
        in_ready = '0;
        if (take && reset_n) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        chan_d  = chan_q;
        if (take) begin
            state_d = ST_FULL;
            data_d  = in_data[grant_idx];
            chan_d  = grant_idx;
            if (!freeze_ptr) begin
                ptr_d = (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + CW'(1);
            end
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_chan  = chan_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: a 2-channel instance driven from a vector table plus a 3-channel
// instance for wrap/skip; force-mode sequences are compiled in when ARB_MUX_FORCE_EN is defined.
module tb_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic [1:0] iv2;
    logic [4:0] d2 [1:0];
    logic [1:0] ir2;
    logic       ov2;
    logic [4:0] od2;
    logic [0:0] oc2;
    logic       ordy2;
    logic       fen2;
    logic [0:0] fsel2;

    logic [2:0] iv3;
    logic [4:0] d3 [2:0];
    logic [2:0] ir3;
    logic       ov3;
    logic [4:0] od3;
    logic [1:0] oc3;
    logic       ordy3;
    logic       fen3;
    logic [1:0] fsel3;

    int checks   = 0;
    int failures = 0;

    arb_mux #(.WIDTH(5), .CHANNELS(2)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (iv2),
        .in_data   (d2),
        .in_ready  (ir2),
        .out_valid (ov2),
        .out_data  (od2),
        .out_chan  (oc2),
`ifdef ARB_MUX_FORCE_EN
        .force_en  (fen2),
        .force_sel (fsel2),
`endif
        .out_ready (ordy2)
    );

    arb_mux #(.WIDTH(5), .CHANNELS(3)) dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (iv3),
        .in_data   (d3),
        .in_ready  (ir3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_chan  (oc3),
`ifdef ARB_MUX_FORCE_EN
        .force_en  (fen3),
        .force_sel (fsel3),
`endif
        .out_ready (ordy3)
    );

    typedef struct {
        logic [1:0] iv;
        logic [4:0] d0;
        logic [4:0] d1;
        logic       ordy;
        logic [1:0] ir;
        logic       ov;
        logic [4:0] od;
        logic [0:0] oc;
    } vec_t;

    vec_t vecs [17];

    typedef struct {
        logic [2:0] iv;
        logic [2:0] ir;
        logic [4:0] od;
        logic [1:0] oc;
    } vec3_t;

    vec3_t v3 [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // inputs, then expected in_ready (before edge) and outputs (after edge); ptr starts at 0
        vecs[0]  = '{2'b11, 5'd0,  5'd31, 1'b1, 2'b01, 1'b1, 5'd0,  1'b0};
        vecs[1]  = '{2'b11, 5'd0,  5'd31, 1'b1, 2'b10, 1'b1, 5'd31, 1'b1};
        vecs[2]  = '{2'b11, 5'd0,  5'd31, 1'b1, 2'b01, 1'b1, 5'd0,  1'b0};
        vecs[3]  = '{2'b11, 5'd0,  5'd31, 1'b1, 2'b10, 1'b1, 5'd31, 1'b1};
        vecs[4]  = '{2'b00, 5'd0,  5'd0,  1'b1, 2'b00, 1'b0, 5'd0,  1'b0};
        vecs[5]  = '{2'b00, 5'd0,  5'd0,  1'b0, 2'b00, 1'b0, 5'd0,  1'b0};
        vecs[6]  = '{2'b11, 5'd7,  5'd9,  1'b0, 2'b01, 1'b1, 5'd7,  1'b0};
        vecs[7]  = '{2'b11, 5'd7,  5'd9,  1'b0, 2'b00, 1'b1, 5'd7,  1'b0};
        vecs[8]  = '{2'b11, 5'd7,  5'd9,  1'b0, 2'b00, 1'b1, 5'd7,  1'b0};
        vecs[9]  = '{2'b11, 5'd7,  5'd9,  1'b0, 2'b00, 1'b1, 5'd7,  1'b0};
        vecs[10] = '{2'b11, 5'd7,  5'd9,  1'b1, 2'b10, 1'b1, 5'd9,  1'b1};
        vecs[11] = '{2'b10, 5'd0,  5'd4,  1'b1, 2'b10, 1'b1, 5'd4,  1'b1};
        vecs[12] = '{2'b01, 5'd12, 5'd0,  1'b1, 2'b01, 1'b1, 5'd12, 1'b0};
        vecs[13] = '{2'b00, 5'd0,  5'd0,  1'b1, 2'b00, 1'b0, 5'd0,  1'b0};
        vecs[14] = '{2'b11, 5'd3,  5'd5,  1'b1, 2'b10, 1'b1, 5'd5,  1'b1};
        vecs[15] = '{2'b01, 5'd6,  5'd0,  1'b0, 2'b00, 1'b1, 5'd5,  1'b1};
        vecs[16] = '{2'b10, 5'd0,  5'd8,  1'b1, 2'b10, 1'b1, 5'd8,  1'b1};

        // 3-channel: data per channel is 1,2,3; ptr starts at 0
        v3[0] = '{3'b010, 3'b010, 5'd2, 2'd1};
        v3[1] = '{3'b011, 3'b001, 5'd1, 2'd0};
        v3[2] = '{3'b100, 3'b100, 5'd3, 2'd2};
        v3[3] = '{3'b111, 3'b001, 5'd1, 2'd0};
        v3[4] = '{3'b111, 3'b010, 5'd2, 2'd1};
        v3[5] = '{3'b111, 3'b100, 5'd3, 2'd2};
        v3[6] = '{3'b111, 3'b001, 5'd1, 2'd0};

        reset_n = 1'b0;
        iv2 = 2'b11; d2[0] = 5'd10; d2[1] = 5'd11; ordy2 = 1'b1; fen2 = 1'b0; fsel2 = '0;
        iv3 = 3'b000; d3[0] = 5'd1; d3[1] = 5'd2; d3[2] = 5'd3; ordy3 = 1'b1; fen3 = 1'b0; fsel3 = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", ov2, 1'b0);
        check("reset_out_data", od2, 5'd0);
        check("reset_out_chan", oc2, 1'b0);
        check("reset_in_ready", ir2, 2'b00);

        @(negedge clk);
        reset_n = 1'b1;
        iv2 = 2'b00;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            iv2 = vecs[i].iv; d2[0] = vecs[i].d0; d2[1] = vecs[i].d1; ordy2 = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i), ir2, vecs[i].ir);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", i), ov2, vecs[i].ov);
            if (vecs[i].ov) begin
                check($sformatf("vec%0d_out_data", i), od2, vecs[i].od);
                check($sformatf("vec%0d_out_chan", i), oc2, vecs[i].oc);
            end
        end

        // asynchronous reset mid-cycle while holding a word
        @(negedge clk);
        iv2 = 2'b11; ordy2 = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_out_valid", ov2, 1'b0);
        check("async_reset_out_data", od2, 5'd0);
        check("async_reset_out_chan", oc2, 1'b0);
        check("async_reset_in_ready", ir2, 2'b00);

        @(negedge clk);
        reset_n = 1'b1;
        iv2 = 2'b11; d2[0] = 5'd21; d2[1] = 5'd22; ordy2 = 1'b1;
        #1;
        check("post_reset_in_ready", ir2, 2'b01);
        @(posedge clk);
        #1;
        check("post_reset_out_valid", ov2, 1'b1);
        check("post_reset_out_data", od2, 5'd21);
        check("post_reset_out_chan", oc2, 1'b0);

`ifdef ARB_MUX_FORCE_EN
        @(negedge clk);
        iv2 = 2'b10;
        @(posedge clk);
        #1;
        check("pre_force_out_chan", oc2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fen2 = 1'b1; fsel2 = 1'b1; iv2 = 2'b11;
            #1;
            check($sformatf("force%0d_in_ready", i), ir2, 2'b10);
            @(posedge clk);
            #1;
            check($sformatf("force%0d_out_chan", i), oc2, 1'b1);
            check($sformatf("force%0d_out_data", i), od2, 5'd22);
        end
        @(negedge clk);
        fen2 = 1'b0;
        #1;
        check("unforce_in_ready", ir2, 2'b01);
        @(posedge clk);
        #1;
        check("unforce_out_chan", oc2, 1'b0);
`endif

        @(negedge clk);
        iv2 = 2'b00;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            iv3 = v3[i].iv;
            #1;
            check($sformatf("ch3_%0d_in_ready", i), ir3, v3[i].ir);
            @(posedge clk);
            #1;
            check($sformatf("ch3_%0d_out_valid", i), ov3, 1'b1);
            check($sformatf("ch3_%0d_out_data", i), od3, v3[i].od);
            check($sformatf("ch3_%0d_out_chan", i), oc3, v3[i].oc);
        end

`ifdef ARB_MUX_FORCE_EN
        @(negedge clk);
        iv3 = 3'b111; fen3 = 1'b1; fsel3 = 2'd3;
        #1;
        check("force_oor_in_ready", ir3, 3'b000);
        @(posedge clk);
        #1;
        check("force_oor_out_valid", ov3, 1'b0);
        @(negedge clk);
        fen3 = 1'b0;
        #1;
        check("force_oor_ptr_frozen", ir3, 3'b010);
`endif

        @(negedge clk);
        iv3 = 3'b000;
        @(posedge clk);
        #1;
        check("ch3_idle_out_valid", ov3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
